// File: rtl/hd44780_byte_sender_if.sv
// Request/handshake bundle between hd44780_controller (master) and hd44780_byte_sender (slave).
interface hd44780_byte_sender_if;
    logic       STB_I;       // transfer request
    logic [7:0] DAT_I;       // byte to send
    logic       i_rs;        // register select for this transfer
    logic       i_nyb_only;  // 4-bit mode: send DAT_I[7:4] only
    logic       o_busy;      // transfer or post-delay in progress
    logic       o_done;      // one-cycle completion pulse

    modport master (
        output STB_I,
        output DAT_I,
        output i_rs,
        output i_nyb_only,
        input  o_busy,
        input  o_done
    );

    modport slave (
        input  STB_I,
        input  DAT_I,
        input  i_rs,
        input  i_nyb_only,
        output o_busy,
        output o_done
    );
endinterface

// File: rtl/hd44780_byte_sender.sv
// HD44780 byte sender: drives the LCD pins in 4-bit or 8-bit mode, generating the E
// setup/high/hold timing and the post-transfer execution delay with one down-counter.
// Optional feature macro: HD44780_LONG_DELAY_EN -- clear/home commands (rs=0, byte 0x01..0x03)
// use LONG_DELAY_CYC as post-transfer wait instead of CMD_DELAY_CYC.
module hd44780_byte_sender #(
    parameter int unsigned BUS_WIDTH      = 4,
    parameter int unsigned E_SETUP_CYC    = 1,
    parameter int unsigned E_HIGH_CYC     = 6,
    parameter int unsigned E_HOLD_CYC     = 1,
    parameter int unsigned CMD_DELAY_CYC  = 444,
    parameter int unsigned LONG_DELAY_CYC = 18240
) (
    input  logic                     CLK_I,
    input  logic                     RST_I,
    hd44780_byte_sender_if.slave     bus,
    output logic [BUS_WIDTH-1:0]     o_lcd_data,
    output logic                     o_rs,
    output logic                     o_e
);

    if (BUS_WIDTH != 4 && BUS_WIDTH != 8) begin : g_bad_width
        $error("hd44780_byte_sender: BUS_WIDTH must be 4 or 8");
    end

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Zero-length phases are stretched to one cycle so every state lasts at least one cycle.
    localparam int unsigned SEff = (E_SETUP_CYC    < 1) ? 1 : E_SETUP_CYC;
    localparam int unsigned HEff = (E_HIGH_CYC     < 1) ? 1 : E_HIGH_CYC;
    localparam int unsigned DEff = (E_HOLD_CYC     < 1) ? 1 : E_HOLD_CYC;
    localparam int unsigned CEff = (CMD_DELAY_CYC  < 1) ? 1 : CMD_DELAY_CYC;
    localparam int unsigned LEff = (LONG_DELAY_CYC < 1) ? 1 : LONG_DELAY_CYC;

    localparam int unsigned MaxCyc = max_u(max_u(max_u(SEff, HEff), max_u(DEff, CEff)), LEff);
    localparam int unsigned CntW   = (MaxCyc < 2) ? 1 : $clog2(MaxCyc + 1);

    typedef logic [CntW-1:0] cnt_t;

    // Counter holds "cycles remaining minus one"; a state exits when it reaches zero.
    localparam cnt_t SReload = cnt_t'(SEff - 1);
    localparam cnt_t HReload = cnt_t'(HEff - 1);
    localparam cnt_t DReload = cnt_t'(DEff - 1);
    localparam cnt_t CReload = cnt_t'(CEff - 1);
    localparam cnt_t LReload = cnt_t'(LEff - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StEHigh,
        StEHold,
        StWait
    } state_e;

    state_e                 state_q, state_d;
    cnt_t                   cnt_q, cnt_d;
    logic [7:0]             byte_q, byte_d;
    logic                   nyb_q, nyb_d;
    logic                   lo_q, lo_d;
    logic                   rs_q, rs_d;
    logic [BUS_WIDTH-1:0]   lcd_q, lcd_d;
    logic                   done_q, done_d;
    cnt_t                   wait_reload;

    // Lane selection: whole byte in 8-bit mode, high or low nybble in 4-bit mode.
    function automatic logic [BUS_WIDTH-1:0] lane_sel(input logic [7:0] b, input logic lo);
        logic [7:0] w;
        if (BUS_WIDTH == 8) begin
            w = b;
        end else if (lo) begin
            w = {b[3:0], b[3:0]};
        end else begin
            w = {b[7:4], b[7:4]};
        end
        return w[BUS_WIDTH-1:0];
    endfunction

    // Post-transfer delay selection for the latched transfer.
    always_comb begin
`ifdef HD44780_LONG_DELAY_EN
        if (!rs_q && !nyb_q && (byte_q == 8'h01 || byte_q == 8'h02 || byte_q == 8'h03)) begin
            wait_reload = LReload;
        end else begin
            wait_reload = CReload;
        end
`else
        wait_reload = CReload;
`endif
    end

    // State and datapath registers; async reset drops E and all pins at once.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            byte_q  <= '0;
            nyb_q   <= 1'b0;
            lo_q    <= 1'b0;
            rs_q    <= 1'b0;
            lcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            nyb_q   <= nyb_d;
            lo_q    <= lo_d;
            rs_q    <= rs_d;
            lcd_q   <= lcd_d;
            done_q  <= done_d;
        end
    end

    // Next-state, counter reload and pin-value latching.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        nyb_d   = nyb_q;
        lo_d    = lo_q;
        rs_d    = rs_q;
        lcd_d   = lcd_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.STB_I) begin
                    state_d = StSetup;
                    cnt_d   = SReload;
                    byte_d  = bus.DAT_I;
                    rs_d    = bus.i_rs;
                    nyb_d   = bus.i_nyb_only && (BUS_WIDTH == 4);
                    lo_d    = 1'b0;
                    lcd_d   = lane_sel(bus.DAT_I, 1'b0);
                end
            end
            StSetup: begin
                if (cnt_q == '0) begin
                    state_d = StEHigh;
                    cnt_d   = HReload;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            StEHigh: begin
                if (cnt_q == '0) begin
                    state_d = StEHold;
                    cnt_d   = DReload;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            StEHold: begin
                if (cnt_q == '0) begin
                    if (BUS_WIDTH == 4 && !nyb_q && !lo_q) begin
                        // Low nybble goes out as a second full transfer.
                        state_d = StSetup;
                        cnt_d   = SReload;
                        lo_d    = 1'b1;
                        lcd_d   = lane_sel(byte_q, 1'b1);
                    end else begin
                        state_d = StWait;
                        cnt_d   = wait_reload;
                    end
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Pin and handshake outputs decoded from state and registers.
    always_comb begin
        o_e        = (state_q == StEHigh);
        bus.o_busy = (state_q != StIdle);
        bus.o_done = done_q;
        o_rs       = rs_q;
        o_lcd_data = lcd_q;
    end

endmodule
